// File: rtl/sample_discriminator_windowed.sv
// Multichannel hysteresis discriminator with pre/post-trigger windows: forwards kept sample
// words after a fixed delay-line latency and emits a {clock, kept-index} stamp per segment start.
module sample_discriminator_windowed #(
  parameter int CHANNELS           = 8,
  parameter int PARALLEL_SAMPLES   = 4,
  parameter int SAMPLE_WIDTH       = 16,
  parameter int PRETRIGGER_DEPTH   = 8,
  parameter int POSTTRIGGER_WIDTH  = 8,
  parameter int APPROX_CLOCK_WIDTH = 48,
  parameter int SAMPLE_INDEX_WIDTH = 13,
  localparam int WORD_W = PARALLEL_SAMPLES * SAMPLE_WIDTH,
  localparam int TS_W   = APPROX_CLOCK_WIDTH + SAMPLE_INDEX_WIDTH,
  localparam int PRE_W  = $clog2(PRETRIGGER_DEPTH + 1),
  localparam int CFG_W  = CHANNELS * 2 * SAMPLE_WIDTH + PRE_W + POSTTRIGGER_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CHANNELS-1:0][WORD_W-1:0] data_in_data_i,
  input  logic [CHANNELS-1:0]             data_in_valid_i,
  output logic                            data_in_ready_o,
  output logic [CHANNELS-1:0][WORD_W-1:0] data_out_data_o,
  output logic [CHANNELS-1:0]             data_out_valid_o,
  output logic [CHANNELS-1:0][TS_W-1:0]   timestamps_out_data_o,
  output logic [CHANNELS-1:0]             timestamps_out_valid_o,
  input  logic [CFG_W-1:0]                config_in_data_i,
  input  logic                            config_in_valid_i,
  output logic                            config_in_ready_o
);

  localparam int D      = PRETRIGGER_DEPTH;
  localparam int SW     = SAMPLE_WIDTH;
  localparam int POST_W = POSTTRIGGER_WIDTH;
  localparam int ACW    = APPROX_CLOCK_WIDTH;
  localparam int SIW    = SAMPLE_INDEX_WIDTH;
  localparam int THR_W  = CHANNELS * 2 * SW;
  localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic logic any_above(input logic [WORD_W-1:0] w, input logic signed [SW-1:0] th);
    logic r;
    r = 1'b0;
    for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
      r = r | ($signed(w[s*SW +: SW]) > th);
    end
    return r;
  endfunction

  function automatic logic all_below(input logic [WORD_W-1:0] w, input logic signed [SW-1:0] th);
    logic r;
    r = 1'b1;
    for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
      r = r & ($signed(w[s*SW +: SW]) < th);
    end
    return r;
  endfunction

  logic signed [SW-1:0] high_q [CHANNELS];
  logic signed [SW-1:0] low_q  [CHANNELS];
  logic [PRE_W-1:0]     pre_q;
  logic [POST_W-1:0]    post_q;
  logic [ACW-1:0]       clock_q;
  logic [PRE_W-1:0]     cfg_pre_s;
  logic [PRE_W-1:0]     cfg_pre_sat_s;
  logic [POST_W-1:0]    cfg_post_s;

  assign data_in_ready_o   = 1'b1;
  assign config_in_ready_o = 1'b1;

  // Split the config payload and clamp the pre-trigger window to the delay-line depth
  always_comb begin
    cfg_pre_s  = config_in_data_i[THR_W +: PRE_W];
    cfg_post_s = config_in_data_i[THR_W + PRE_W +: POST_W];
    if (cfg_pre_s > PRE_W'(D)) begin
      cfg_pre_sat_s = PRE_W'(D);
    end else begin
      cfg_pre_sat_s = cfg_pre_s;
    end
  end

  // Shared configuration registers and free-running clock counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clock_q <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        high_q[c] <= SMAX;
        low_q[c]  <= SMAX;
      end
    end else if (config_in_valid_i) begin
      clock_q <= '0;
      pre_q   <= cfg_pre_sat_s;
      post_q  <= cfg_post_s;
      for (int c = 0; c < CHANNELS; c++) begin
        low_q[c]  <= $signed(config_in_data_i[c*2*SW +: SW]);
        high_q[c] <= $signed(config_in_data_i[c*2*SW + SW +: SW]);
      end
    end else begin
      clock_q <= clock_q + ACW'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e                   state_q;
    state_e                   state_d;
    logic [POST_W-1:0]        cnt_q;
    logic [POST_W-1:0]        cnt_d;
    logic [D-1:0][WORD_W-1:0] stage_data_q;
    logic [D-1:0]             stage_valid_q;
    logic [D-1:0]             stage_keep_q;
    logic [D-1:0]             keep_mark_s;
    logic [SIW-1:0]           kept_q;
    logic [SIW-1:0]           kept_inc_s;
    logic                     hi_s;
    logic                     lo_s;
    logic                     keep_in_s;
    logic                     trig_s;
    logic [WORD_W-1:0]        out_data_q;
    logic                     out_valid_q;
    logic [TS_W-1:0]          ts_data_q;
    logic                     ts_valid_q;

    assign hi_s = any_above(data_in_data_i[c], high_q[c]);
    assign lo_s = all_below(data_in_data_i[c], low_q[c]);

    // Hysteresis state machine next-state and keep decision for the incoming word
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      keep_in_s = 1'b0;
      trig_s    = 1'b0;
      if (data_in_valid_i[c]) begin
        case (state_q)
          ST_IDLE: begin
            if (hi_s) begin
              state_d   = ST_ACTIVE;
              keep_in_s = 1'b1;
              trig_s    = 1'b1;
            end else begin
              keep_in_s = 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (!lo_s) begin
              keep_in_s = 1'b1;
            end else if (post_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = post_q;
            end
          end
          ST_HOLD: begin
            keep_in_s = 1'b1;
            if (hi_s) begin
              state_d = ST_ACTIVE;
            end else begin
              cnt_d = cnt_q - POST_W'(1);
              if (cnt_q == POST_W'(1)) begin
                state_d = ST_IDLE;
              end else begin
                state_d = ST_HOLD;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end else begin
        // Invalid words inside a segment are marked so a later pre-window stops at them
        keep_in_s = (state_q != ST_IDLE);
      end
    end

    // Pre-trigger back-marking, stopping at the first stage already kept
    always_comb begin
      logic           blocked;
      logic [SIW-1:0] pre_inc;
      keep_mark_s = stage_keep_q;
      blocked     = 1'b0;
      pre_inc     = '0;
      for (int i = 0; i < D; i++) begin
        if (trig_s && !blocked && (i < int'(pre_q))) begin
          if (stage_keep_q[i]) begin
            blocked = 1'b1;
          end else begin
            keep_mark_s[i] = 1'b1;
            pre_inc        = pre_inc + SIW'(stage_valid_q[i]);
          end
        end else begin
          blocked = blocked;
        end
      end
      kept_inc_s = pre_inc + SIW'(data_in_valid_i[c] & keep_in_s);
    end

    // Delay line, state, kept counter and registered outputs
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q       <= ST_IDLE;
        cnt_q         <= '0;
        stage_data_q  <= '0;
        stage_valid_q <= '0;
        stage_keep_q  <= '0;
        kept_q        <= '0;
        out_data_q    <= '0;
        out_valid_q   <= 1'b0;
        ts_data_q     <= '0;
        ts_valid_q    <= 1'b0;
      end else begin
        stage_data_q  <= {stage_data_q[D-2:0], data_in_data_i[c]};
        stage_valid_q <= {stage_valid_q[D-2:0], data_in_valid_i[c]};
        out_data_q    <= stage_data_q[D-1];
        ts_data_q     <= {clock_q, kept_q};
        if (config_in_valid_i) begin
          state_q      <= ST_IDLE;
          cnt_q        <= '0;
          stage_keep_q <= '0;
          kept_q       <= '0;
          out_valid_q  <= 1'b0;
          ts_valid_q   <= 1'b0;
        end else begin
          state_q      <= state_d;
          cnt_q        <= cnt_d;
          stage_keep_q <= {keep_mark_s[D-2:0], keep_in_s};
          kept_q       <= kept_q + kept_inc_s;
          out_valid_q  <= stage_valid_q[D-1] & keep_mark_s[D-1];
          ts_valid_q   <= trig_s;
        end
      end
    end

    assign data_out_data_o[c]        = out_data_q;
    assign data_out_valid_o[c]       = out_valid_q;
    assign timestamps_out_data_o[c]  = ts_data_q;
    assign timestamps_out_valid_o[c] = ts_valid_q;
  end

endmodule
